// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN = 64;

    // RV64M funct3 encoding of the operation.
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_t;

    // Quotient returned for a zero divisor (the remainder is the dividend).
    localparam logic [XLEN-1:0] DIV0_QUOT   = '1;
    // Signed overflow case: most-negative dividend divided by -1.
    localparam logic [XLEN-1:0] OVF_QUOT    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] OVF_REM     = '0;
    localparam logic [XLEN-1:0] OVF_DIVISOR = '1;

endpackage

// File: rtl/muldiv_abs.sv
// Combinational magnitude extraction: two's-complement value -> magnitude plus sign.
module muldiv_abs
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] val,
    input  logic             is_signed,
    output logic [WIDTH-1:0] mag,
    output logic             neg
);

    // Negative only when the operand is interpreted as signed and its MSB is set.
    always_comb begin
        neg = is_signed & val[WIDTH-1];
        mag = neg ? (~val + 1'b1) : val;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
module muldiv_unit #(
    parameter int unsigned XLEN = muldiv_pkg::XLEN
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    import muldiv_pkg::*;

    localparam logic [6:0] LAST_ITER = 7'(XLEN - 1);

    muldiv_state_t   state_q, state_d;
    muldiv_op_t      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [6:0]      cnt_q, cnt_d;
    logic            load_q, load_d;

    logic            a_signed, b_signed, is_rem, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            sign_a, sign_b;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;

    // Operand signedness and special-case detection from the latched request.
    always_comb begin
        a_signed = op_q inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        b_signed = op_q inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        is_rem   = op_q inside {OP_REM, OP_REMU};
        div_zero = (b_q == '0);
        div_ovf  = (op_q inside {OP_DIV, OP_REM}) && (a_q == OVF_QUOT) && (b_q == OVF_DIVISOR);
    end

    muldiv_abs #(.WIDTH(XLEN)) u_abs_a (
        .val       (a_q),
        .is_signed (a_signed),
        .mag       (mag_a),
        .neg       (sign_a)
    );

    muldiv_abs #(.WIDTH(XLEN)) u_abs_b (
        .val       (b_q),
        .is_signed (b_signed),
        .mag       (mag_b),
        .neg       (sign_b)
    );

    // Next-state, iteration datapath and result selection.
    // The first cycle in MUL/DIV (load_q) seeds the accumulator from the operand
    // magnitudes and screens divide special cases; the 64 iterations follow it.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        load_d   = load_q;
        result_d = result_q;

        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_a} : '0);
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_trial - {1'b0, mag_b};
        prod_s    = (sign_a ^ sign_b) ? (~acc_q + 1'b1) : acc_q;
        quo_s     = (sign_a ^ sign_b) ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem_s     = sign_a ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = muldiv_op_t'(op);
                    a_d     = A;
                    b_d     = B;
                    cnt_d   = '0;
                    load_d  = 1'b1;
                    state_d = op[2] ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                if (load_q) begin
                    acc_d  = {{XLEN{1'b0}}, mag_b};
                    load_d = 1'b0;
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q == LAST_ITER) state_d = ST_FIX;
                end
            end
            ST_DIV: begin
                if (load_q) begin
                    load_d = 1'b0;
                    if (div_zero || div_ovf) state_d = ST_FIX;
                    else                     acc_d   = {{XLEN{1'b0}}, mag_a};
                end else begin
                    acc_d = div_diff[XLEN] ? {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                           : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q == LAST_ITER) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (!op_q[2])     result_d = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
                else if (div_zero) result_d = is_rem ? a_q : DIV0_QUOT;
                else if (div_ovf)  result_d = is_rem ? OVF_REM : OVF_QUOT;
                else               result_d = is_rem ? rem_s : quo_s;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // All state, counter, operand and accumulator registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            load_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            load_q   <= load_d;
            result_q <= result_d;
        end
    end

    assign busy   = state_q inside {ST_MUL, ST_DIV, ST_FIX};
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops vs. an arithmetic model.
module tb_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [63:0] A = '0;
    logic [63:0] B = '0;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    muldiv_unit #(.XLEN(64)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference result from plain arithmetic on sign/zero-extended operands.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, ua, ub, p;
        logic signed [63:0]  da, db;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        ua = {64'b0, a};
        ub = {64'b0, b};
        da = a;
        db = b;
        p  = '0;
        case (o)
            3'd0: begin p = sa * sb; return p[63:0];   end
            3'd1: begin p = sa * sb; return p[127:64]; end
            3'd2: begin p = sa * ub; return p[127:64]; end
            3'd3: begin p = ua * ub; return p[127:64]; end
            3'd4: begin
                if (b == 0) return ONES;
                if (a == MIN64 && b == ONES) return a;
                return da / db;
            end
            3'd5: begin
                if (b == 0) return ONES;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN64 && b == ONES) return 64'd0;
                return da % db;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        if (o[2] && (b == 0 || ((o == 3'd4 || o == 3'd6) && a == MIN64 && b == ONES))) return 2;
        return 66;
    endfunction

    // Issue one request; lat = index n of the cycle after E(n) in which done is seen (-1 on timeout).
    task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b, input int inj_at,
                          output logic [63:0] res, output int lat, output bit busy_ok);
        @(negedge Clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge Clk);
        #1 start = 1'b0;
        lat = -1;
        busy_ok = 1'b1;
        res = 'x;
        for (int n = 0; n < 200; n++) begin
            @(negedge Clk);
            if (n == inj_at) begin
                start = 1'b1; op = ~o; A = ~a; B = b + 64'd5;
            end
            if (n == inj_at + 1) start = 1'b0;
            if (done === 1'b1) begin
                lat = n;
                res = result;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic do_step(input string tag, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp_res, input int exp_lat, input int inj_at);
        logic [63:0] res;
        int          lat;
        bit          busy_ok;
        run_op(o, a, b, inj_at, res, lat, busy_ok);
        check({tag, " result"}, res, exp_res);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy while running"}, 64'(busy_ok), 64'd1);
        if (lat >= 0) check({tag, " busy in done cycle"}, 64'(busy), 64'd0);
        @(negedge Clk);
        check({tag, " done one cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        bit seen_done;
        logic [2:0]  ro;
        logic [63:0] ra, rb;

        // Reset state
        #3;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", result, 64'd0);
        @(negedge Clk);
        Reset = 1'b0;

        do_step("MUL 7*-3", 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66, -1);

        // Reset in the middle of a divide
        @(negedge Clk);
        start = 1'b1; op = 3'd4; A = 64'd1000; B = 64'd3;
        @(posedge Clk);
        #1 start = 1'b0;
        repeat (30) @(posedge Clk);
        #1 Reset = 1'b1;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort result", result, 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge Clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("abort no done", 64'(seen_done), 64'd0);
        do_step("MUL 3*4 after abort", 3'd0, 64'd3, 64'd4, 64'd12, 66, -1);

        do_step("MULHU ones*2", 3'd3, ONES, 64'd2, 64'd1, 66, -1);
        do_step("MULH -1*2", 3'd1, ONES, 64'd2, ONES, 66, -1);
        do_step("DIV -7/2", 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, -1);
        do_step("REM -7%2", 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 66, -1);
        do_step("DIVU 100/7", 3'd5, 64'd100, 64'd7, 64'd14, 66, -1);
        do_step("REMU 100%7", 3'd7, 64'd100, 64'd7, 64'd2, 66, -1);
        do_step("DIVU 5/0", 3'd5, 64'd5, 64'd0, ONES, 2, -1);
        do_step("REM 5/0", 3'd6, 64'd5, 64'd0, 64'd5, 2, -1);
        do_step("DIV ovf", 3'd4, MIN64, ONES, MIN64, 2, -1);
        do_step("REM ovf", 3'd6, MIN64, ONES, 64'd0, 2, -1);
        do_step("MULHSU -1*ones", 3'd2, ONES, ONES, ONES, 66, -1);

        // Second start during a multiply must be ignored
        do_step("MUL with ignored start", 3'd0, 64'd5, 64'd9, 64'd45, 66, 9);
        seen_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge Clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("ignored start no extra done", 64'(seen_done), 64'd0);
        check("ignored start result held", result, 64'd45);

        // Randomized operations against the arithmetic model
        for (int k = 0; k < 32; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: begin ra = 64'($urandom_range(0, 1000)); rb = 64'($urandom_range(1, 50)); end
                1: rb = '0;
                2: begin ra = MIN64; rb = ONES; end
                3: begin ra = -64'($urandom_range(1, 1000)); rb = 64'($urandom_range(1, 50)); end
                default: ;
            endcase
            do_step($sformatf("rand%0d op%0d", k, ro), ro, ra, rb, ref_result(ro, ra, rb), ref_latency(ro, ra, rb), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
